// File: rtl/ones_word_gen.sv
// ones_word_gen: fills an N-bit word one bit per cycle with `count` ones, packed from bit 0 or from bit N-1.
module ones_word_gen #(
  parameter int N  = 127,
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] count,
  input  logic          msb_first,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  word,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  state_t        r_state;
  logic [CW-1:0] r_j;
  logic [CW-1:0] r_cnt;
  logic          r_msb;
  logic [N-1:0]  r_word;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;
  logic [CW-1:0] w_pos;
  assign w_pos     = r_msb ? CW'(N - 1) - r_j : r_j;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign word      = r_word;
  // Status flags are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_j         <= '0;
      r_cnt       <= '0;
      r_msb       <= 1'b0;
      r_word      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_cnt      <= count;
          r_msb      <= msb_first;
          r_word     <= '0;
          r_j        <= '0;
          r_state    <= FILL;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
        end
        FILL: begin
          r_word[w_pos] <= r_j < r_cnt;
          // j stops at N-1 rather than wrapping back to zero.
          if (r_j == CW'(N - 1)) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ones_word_gen.sv
// tb_ones_word_gen: directed checks of ones_word_gen latency, patterns, backpressure and reset abort.
module tb_ones_word_gen;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [6:0]   count;
  logic         msb_first;
  logic         out_valid;
  logic         out_ready;
  logic [126:0] word;
  logic         busy;
  int           n_chk = 0;
  int           n_fail = 0;
  int           lat;
  int           off;
  int           c;
  logic         seen;
  logic [126:0] v64;
  ones_word_gen #(.N(127), .CW(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .count(count), .msb_first(msb_first), .out_valid(out_valid),
    .out_ready(out_ready), .word(word), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [126:0] exp_word(input int cn, input bit m);
    logic [126:0] e;
    for (int i = 0; i < 127; i++) e[i] = m ? (126 - i < cn) : (i < cn);
    return e;
  endfunction
  task automatic req(input int cn, input bit m, input bit ordy, output int l);
    count     = 7'(cn);
    msb_first = m;
    out_ready = ordy;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 400) begin
      @(posedge clk); #1;
      l++;
    end
  endtask
  task automatic done();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b1; count = 7'd9; msb_first = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_word", 128'(word), 128'(0));
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 128'(busy), 128'(0));
    req(5, 0, 1, lat);
    chk("c5_lat", 128'(lat), 128'(128));
    chk("c5_word", 128'(word), 128'h1F);
    @(posedge clk); #1;
    chk("c5_in_ready", 128'(in_ready), 128'(1));
    chk("c5_out_valid_off", 128'(out_valid), 128'(0));
    req(3, 1, 0, lat);
    chk("c3m_lat", 128'(lat), 128'(128));
    chk("c3m_word", 128'(word), 128'({3'b111, 124'b0}));
    chk("c3m_pop", 128'($countones(word)), 128'(3));
    done();
    req(0, 0, 0, lat);
    chk("c0_lat", 128'(lat), 128'(128));
    chk("c0_word", 128'(word), 128'(0));
    done();
    req(127, 0, 0, lat);
    chk("c127_lat", 128'(lat), 128'(128));
    chk("c127_word", 128'(word), {1'b0, {127{1'b1}}});
    done();
    v64 = (127'(1) << 64) - 127'(1);
    req(64, 0, 0, lat);
    chk("c64_lat", 128'(lat), 128'(128));
    count = 7'd1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_ov_%0d", k), 128'(out_valid), 128'(1));
      chk($sformatf("hold_word_%0d", k), 128'(word), 128'(v64));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_rel_in_ready", 128'(in_ready), 128'(1));
    chk("hold_rel_word", 128'(word), 128'(v64));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("turn_busy", 128'(busy), 128'(1));
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("turn_lat", 128'(lat), 128'(128));
    chk("turn_word", 128'(word), 128'(1));
    done();
    count = 7'd100; msb_first = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("abort_fill_busy", 128'(busy), 128'(1));
    chk("abort_fill_in_ready", 128'(in_ready), 128'(0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_word", 128'(word), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    seen = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    chk("abort_no_ov", 128'(seen), 128'(0));
    req(2, 0, 1, lat);
    chk("post_abort_lat", 128'(lat), 128'(128));
    chk("post_abort_word", 128'(word), 128'h3);
    @(posedge clk); #1;
    off = int'($urandom_range(0, 127));
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 128; i++) begin
        c = (i + off) % 128;
        req(c, m[0], 1, lat);
        chk($sformatf("sw_m%0d_c%0d_word", m, c), 128'(word), 128'(exp_word(c, m[0])));
        chk($sformatf("sw_m%0d_c%0d_pop", m, c), 128'($countones(word)), 128'(c));
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ones_word_gen.md
ONES_WORD_GEN -- requirements
Module: ones_word_gen

Interface
REQ-001 SHALL have parameter N, default 127, meaning output word width.
REQ-002 SHALL have parameter CW, default 7, meaning count width; N = 2^CW - 1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request carries a valid count.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port count  input  CW  number of 1 bits to place in the word.
REQ-008 SHALL have port msb_first  input  1  0: ones packed from bit 0 upward; 1: ones packed from bit N-1 downward.
REQ-009 SHALL have port out_valid  output  1  word holds a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-011 SHALL have port word  output  N  generated word, exactly count bits set.
REQ-012 SHALL have port busy  output  1  high in FILL and HOLD states.

Function
REQ-013 SHALL implement three states: IDLE, FILL, HOLD.
REQ-014 IDLE: in_ready=1, out_valid=0, busy=0; on in_valid=1 SHALL register count and msb_first, clear word to 0, clear bit index j to 0, go to FILL.
REQ-015 FILL: in_ready=0, busy=1; each cycle SHALL write one bit, position j (msb_first=0) or N-1-j (msb_first=1), value 1 iff j < registered count, then increment j.
REQ-016 FILL SHALL last exactly N cycles regardless of count; after bit j=N-1 is written, go to HOLD.
REQ-017 HOLD: out_valid=1, busy=1, in_ready=0; word SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 HOLD with out_ready=1 SHALL complete the transfer that cycle and go to IDLE next cycle; word keeps its value until the next accepted request.
REQ-019 Latency: out_valid SHALL rise N+1 cycles after the edge sampling in_valid=1 in IDLE (N FILL cycles, then HOLD).
REQ-020 in_valid and count/msb_first changes in FILL or HOLD SHALL be ignored (no capture, no effect on the running result).
REQ-021 No same-cycle turnaround: a request presented while out_valid=1 SHALL be accepted no earlier than the first IDLE cycle.
REQ-022 count=0 SHALL yield word all zeros; count=N SHALL yield word all ones; for any count, popcount(word)=count.
REQ-023 Bit index j SHALL be CW bits wide and SHALL NOT wrap within a request (maximum N-1 before HOLD).
REQ-024 For msb_first=0, word SHALL equal (2^count - 1); for msb_first=1, word SHALL equal that value bit-reversed over N bits.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force state IDLE, word=0, j=0, registered count=0, registered msb_first=0.
REQ-026 Reset outputs: in_ready=1, out_valid=0, busy=0, word=0 from the first edge with rst_n=0.
REQ-027 Reset asserted during FILL or HOLD SHALL abort the operation; no out_valid pulse SHALL follow from the aborted request.
REQ-028 in_valid sampled in the same cycle as rst_n=0 SHALL NOT be captured.

Verification
REQ-029 count=5, msb_first=0, out_ready=1 -> out_valid after 128 cycles, word=0x1F, then in_ready=1 next cycle.
REQ-030 count=3, msb_first=1 -> word bits [126:124]=1, all others 0, popcount 3.
REQ-031 count=0 and count=127 back to back -> all-zero word, then all-ones word; each 128-cycle latency.
REQ-032 count=64, out_ready held 0 for 10 cycles in HOLD -> out_valid and word=2^64-1 stable for all 10 cycles; in_valid with count=1 during HOLD ignored.
REQ-033 rst_n=0 at FILL cycle 40 of count=100 -> next cycle in_ready=1, word=0, out_valid never asserts for that request; fresh request count=2 yields word=0x3.
REQ-034 Random sweep of all counts 0..127 with both msb_first values -> popcount(word)=count and REQ-024 pattern match for every result.
